// File: rtl/cic_decim_ctrl_if.sv
// Control/handshake bundle between the DDC control registers, the strobe
// source and the cic_decim sequencer.
interface cic_decim_ctrl_if;
  logic       run;
  logic       set_stb;
  logic [7:0] set_rate;
  logic [2:0] set_gain;
  logic       strobe_in;
  logic       cic_enable;
  logic [7:0] cic_rate;
  logic [2:0] cic_gain_bits;
  logic       strobe_out;
  logic       valid_out;
  logic       busy;

  modport master (
    output run, set_stb, set_rate, set_gain, strobe_in,
    input  cic_enable, cic_rate, cic_gain_bits, strobe_out, valid_out, busy
  );

  modport slave (
    input  run, set_stb, set_rate, set_gain, strobe_in,
    output cic_enable, cic_rate, cic_gain_bits, strobe_out, valid_out, busy
  );
endinterface

// File: rtl/cic_decim_ctrl.sv
// Sequencer for one cic_decim instance: divides the input strobe by the
// applied rate, flushes the CIC on configuration changes and qualifies
// output samples once the pipeline has filled.
module cic_decim_ctrl #(
  parameter int unsigned N                = 4,
  parameter int unsigned log2_of_max_rate = 7
) (
  input  logic            clock,
  input  logic            reset,
  cic_decim_ctrl_if.slave bus
);

  localparam logic [8:0]  MAX_RATE = 9'(2 ** log2_of_max_rate);
  localparam int unsigned FILL_W   = (N < 1) ? 1 : $clog2(N + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_FILL,
    ST_RUN
  } state_t;

  state_t            state;
  logic [7:0]        dec_cnt;
  logic [FILL_W-1:0] fill_cnt;
  logic              flush_cnt;
  logic [7:0]        shadow_rate;
  logic [2:0]        shadow_gain;
  logic              pending;
  logic [7:0]        rate_q;
  logic [2:0]        gain_q;
  logic              enable_q;
  logic              strobe_q;
  logic              qual_a;
  logic              qual_b;
  logic              valid_q;
  logic              busy_q;

  function automatic logic [7:0] clamp_rate(input logic [7:0] r);
    if (r == '0) begin
      return 8'd1;
    end
    if ({1'b0, r} > MAX_RATE) begin
      return MAX_RATE[7:0];
    end
    return r;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      dec_cnt     <= '0;
      fill_cnt    <= '0;
      flush_cnt   <= 1'b0;
      shadow_rate <= 8'd4;
      shadow_gain <= '0;
      pending     <= 1'b0;
      rate_q      <= 8'd4;
      gain_q      <= '0;
      enable_q    <= 1'b0;
      strobe_q    <= 1'b0;
      qual_a      <= 1'b0;
      qual_b      <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      qual_a   <= 1'b0;
      qual_b   <= qual_a;
      valid_q  <= qual_b;

      // Shadow config is applied whenever the CIC is held disabled.
      if (state == ST_IDLE || state == ST_FLUSH) begin
        rate_q  <= shadow_rate;
        gain_q  <= shadow_gain;
        pending <= 1'b0;
      end

      if (!bus.run) begin
        state     <= ST_IDLE;
        enable_q  <= 1'b0;
        busy_q    <= 1'b0;
        dec_cnt   <= '0;
        fill_cnt  <= '0;
        flush_cnt <= 1'b0;
        qual_a    <= 1'b0;
        qual_b    <= 1'b0;
        valid_q   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state     <= ST_FLUSH;
            flush_cnt <= 1'b0;
            busy_q    <= 1'b1;
          end
          ST_FLUSH: begin
            if (flush_cnt) begin
              state    <= ST_FILL;
              enable_q <= 1'b1;
              dec_cnt  <= '0;
              fill_cnt <= '0;
            end else begin
              flush_cnt <= 1'b1;
            end
          end
          ST_FILL, ST_RUN: begin
            if (bus.strobe_in) begin
              if (dec_cnt == rate_q - 8'd1) begin
                dec_cnt  <= '0;
                strobe_q <= 1'b1;
                // Boundary with a pending config: pulse still issued, never qualified.
                if (pending) begin
                  state     <= ST_FLUSH;
                  flush_cnt <= 1'b0;
                  enable_q  <= 1'b0;
                  busy_q    <= 1'b1;
                  pending   <= 1'b0;
                end else if (state == ST_FILL) begin
                  if (fill_cnt == FILL_W'(N)) begin
                    state  <= ST_RUN;
                    busy_q <= 1'b0;
                  end else begin
                    fill_cnt <= fill_cnt + 1'b1;
                  end
                end else begin
                  qual_a <= 1'b1;
                end
              end else begin
                dec_cnt <= dec_cnt + 8'd1;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end

      // Placed last so a new request always re-arms pending, last one wins.
      if (bus.set_stb) begin
        shadow_rate <= clamp_rate(bus.set_rate);
        shadow_gain <= bus.set_gain;
        pending     <= 1'b1;
      end
    end
  end

  assign bus.cic_enable    = enable_q;
  assign bus.cic_rate      = rate_q;
  assign bus.cic_gain_bits = gain_q;
  assign bus.strobe_out    = strobe_q;
  assign bus.valid_out     = valid_q;
  assign bus.busy          = busy_q;

endmodule
